// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   SYNC_BYTE  : frame start marker.
//   ADDR_STEP  : byte-address increment per written word.
//   state_t    : loader FSM state encoding. ST_CSUM is only present when
//                IMEM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes (little-endian, first byte lands in bits 7:0) into a
// 32-bit word and flags the byte that completes it.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   byte_valid_i  : byte_i is consumed this cycle
//   byte_i        : incoming byte
//   word_o        : assembled word, valid while word_done_o is high
//   word_done_o   : high in the cycle the fourth byte is presented
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;

  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is available in the same cycle.
  assign word_o      = {byte_i, shift_q};
  assign word_done_o = byte_valid_i && (lane_q == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid_i) begin
      lane_q  <= lane_q + 2'd1;
      shift_q <= {byte_i, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed program image and writes it
// word by word into the instruction memory, holding the core in reset until
// a complete, valid image has been loaded.
// Frame: A5, N (16-bit LE word count), N x 4-byte LE words[, XOR checksum].
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds trailing checksum byte).
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   rx_valid_i, rx_data_i  : byte stream in
//   rx_ready_o             : always ready outside reset
//   we_o, waddr_o, wdata_o : one-cycle write strobe, byte address, word
//   cpu_rst_o              : core reset, released only in DONE
//   done_o, error_o        : status of the last load
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SYNC   | hunting for the sync byte
// ST_LEN_LO | expecting count low byte
// ST_LEN_HI | expecting count high byte, length validated here
// ST_DATA   | receiving data words, one write per completed word
// ST_CSUM   | expecting checksum byte (checksum build only)
// ST_DONE   | image loaded, core released
// ST_ERROR  | load aborted, waiting for a new sync byte
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NUMWORDS  = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_ready_o,
  output logic                 we_o,
  output logic [31:0]          waddr_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  output logic                 cpu_rst_o,
  output logic                 done_o,
  output logic                 error_o
);

  state_t      state_q;
  logic [7:0]  len_lo_q;
  logic [15:0] n_words_q;
  logic [15:0] word_idx_q;
  logic        accept;
  logic        asm_valid;
  logic        word_done;
  logic [31:0] asm_word;
  logic [31:0] len_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign rx_ready_o = ~rst_i;
  assign accept     = rx_valid_i && rx_ready_o;
  assign asm_valid  = accept && (state_q == ST_DATA);
  // Zero-extended so the range check against NUMWORDS cannot overflow.
  assign len_full   = {16'd0, rx_data_i, len_lo_q};

  word_assembler u_word_assembler (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data_i),
    .word_o       (asm_word),
    .word_done_o  (word_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_SYNC;
      len_lo_q   <= 8'd0;
      n_words_q  <= 16'd0;
      word_idx_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
      we_o       <= 1'b0;
      waddr_o    <= 32'd0;
      wdata_o    <= '0;
      cpu_rst_o  <= 1'b1;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (accept && rx_data_i == SYNC_BYTE) state_q <= ST_LEN_LO;
        end

        ST_LEN_LO: begin
          if (accept) begin
            len_lo_q <= rx_data_i;
            state_q  <= ST_LEN_HI;
          end
        end

        ST_LEN_HI: begin
          if (accept) begin
            n_words_q  <= {rx_data_i, len_lo_q};
            word_idx_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
            if (len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
`endif
            end else if (len_full > NUMWORDS) begin
              state_q <= ST_ERROR;
              error_o <= 1'b1;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) csum_q <= csum_q ^ rx_data_i;
`endif
          if (word_done) begin
            we_o    <= 1'b1;
            waddr_o <= 32'(word_idx_q) * ADDR_STEP;
            wdata_o <= asm_word;
            // The last word leaves DATA without bumping the index, so it
            // never exceeds N-1.
            if (word_idx_q == n_words_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
`endif
            end else begin
              word_idx_q <= word_idx_q + 16'd1;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            if (rx_data_i == csum_q) begin
              state_q   <= ST_DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              error_o <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          if (accept && rx_data_i == SYNC_BYTE) begin
            state_q   <= ST_LEN_LO;
            cpu_rst_o <= 1'b1;
            done_o    <= 1'b0;
            error_o   <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A frame-parsing reference model
// derives the expected writes and final status from the byte stream.
// Honours IMEM_LOADER_CHECKSUM_EN to match the design build.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned NUMWORDS = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        error_o;

  imem_loader #(.DATAWIDTH(32), .NUMWORDS(NUMWORDS)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .cpu_rst_o  (cpu_rst_o),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]  stim_q[$];
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          exp_status;   // 0 = loading/idle, 1 = done, 2 = error

  always @(negedge clk_i) if (we_o === 1'b1) got_q.push_back({waddr_o, wdata_o});

  // Reference: parse the stream as a sequence of frames.
  task automatic model_run();
    int i, n;
    logic [7:0]  cs;
    logic [31:0] w;
    bit stop;
    exp_q.delete();
    i = 0;
    stop = 0;
    while (i < stim_q.size() && !stop) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      exp_status = 0;
      i++;
      if (i + 2 > stim_q.size()) begin
        stop = 1;
        continue;
      end
      n = int'({stim_q[i+1], stim_q[i]});
      i += 2;
      if (n > int'(NUMWORDS)) begin
        exp_status = 2;
        continue;
      end
      cs = 8'd0;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > stim_q.size()) begin
          stop = 1;
          break;
        end
        w = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
        cs = cs ^ stim_q[i] ^ stim_q[i+1] ^ stim_q[i+2] ^ stim_q[i+3];
        exp_q.push_back({32'(k * 4), w});
        i += 4;
      end
      if (stop) continue;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (i >= stim_q.size()) begin
        stop = 1;
        continue;
      end
      exp_status = (stim_q[i] == cs) ? 1 : 2;
      i++;
`else
      exp_status = 1;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) begin
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
        @(posedge clk_i); #1;
      end
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  // Appends XOR of stim_q[start..] when the checksum build is active.
  task automatic add_csum(input int start);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'd0;
    for (int j = start; j < stim_q.size(); j++) c ^= stim_q[j];
    stim_q.push_back(c);
`else
    if (start < 0) stim_q.push_back(8'd0);
`endif
  endtask

  task automatic build_frame(input int n, input bit bad_csum);
    int start;
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'(n));
    stim_q.push_back(8'(n >> 8));
    start = stim_q.size();
    for (int j = 0; j < 4 * n; j++) stim_q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_csum(start);
    if (bad_csum) stim_q[stim_q.size()-1] = stim_q[stim_q.size()-1] ^ 8'h01;
`else
    if (bad_csum && start < 0) stim_q.push_back(8'd0);
`endif
  endtask

  task automatic check_status(input string tag);
    check({tag, ".done"},    done_o,    exp_status == 1);
    check({tag, ".error"},   error_o,   exp_status == 2);
    check({tag, ".cpu_rst"}, cpu_rst_o, exp_status != 1);
  endtask

  task automatic run_stream(input string tag, input bit gaps, input bit chk_restart);
    model_run();
    got_q.delete();
    for (int j = 0; j < stim_q.size(); j++) begin
      send_byte(stim_q[j], gaps);
      if (chk_restart && j == 0) begin
        check({tag, ".restart_cpu_rst"}, cpu_rst_o, 1'b1);
        check({tag, ".restart_done"},    done_o,    1'b0);
      end
    end
    repeat (4) @(posedge clk_i);
    #1;
    check({tag, ".nwrites"}, got_q.size(), exp_q.size());
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      check($sformatf("%s.wr%0d", tag, j), got_q[j], exp_q[j]);
    if (exp_q.size() > 0)
      check({tag, ".hold"}, {waddr_o, wdata_o}, exp_q[exp_q.size()-1]);
    check_status(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_ready"}, rx_ready_o, 1'b0);
    check({tag, ".we"},       we_o,       1'b0);
    check({tag, ".waddr"},    waddr_o,    32'd0);
    check({tag, ".wdata"},    wdata_o,    32'd0);
    check({tag, ".cpu_rst"},  cpu_rst_o,  1'b1);
    check({tag, ".done"},     done_o,     1'b0);
    check({tag, ".error"},    error_o,    1'b0);
  endtask

  initial begin
    int n, mode, pre;
    rst_i      = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    exp_status = 0;
    #2;
    check_reset_outputs("rst0");
    @(posedge clk_i); #1;
    check_reset_outputs("rst1");
    rst_i = 1'b0;
    #1;
    check("rst_rel.rx_ready", rx_ready_o, 1'b1);

    // Two-word frame
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_csum(3);
    run_stream("two_words", 0, 0);
    check("two_words.w0", exp_q[0], {32'd0, 32'h12345678});

    // Leading garbage then one word
    stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    add_csum(5);
    run_stream("garbage", 0, 0);

    // Over-length frame, then an empty frame
    stim_q = '{8'hA5, 8'h01, 8'h10};
    run_stream("too_long", 0, 0);
    stim_q = '{8'hA5, 8'h00, 8'h00};
    add_csum(3);
    run_stream("empty", 0, 0);

    // Reset in the middle of word 0
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    got_q.delete();
    foreach (stim_q[j]) send_byte(stim_q[j], 0);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_status = 0;
    check("mid_rst.nwrites", got_q.size(), 0);
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    add_csum(3);
    run_stream("after_rst", 0, 0);

    // Restart from DONE
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h20, 8'h03, 8'h40};
    add_csum(3);
    run_stream("restart", 0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_stream("csum_ok", 0, 1);
    stim_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_stream("csum_bad", 0, 0);
`endif

    // Randomized frames with idle gaps and junk prefixes
    for (int it = 0; it < 30; it++) begin
      stim_q.delete();
      pre = $urandom_range(0, 3);
      for (int j = 0; j < pre; j++) stim_q.push_back(8'($urandom_range(0, 8'hA4)));
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        n = $urandom_range(NUMWORDS + 1, 65535);
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
      end else if (mode == 1) begin
        build_frame(0, 0);
      end else begin
        build_frame($urandom_range(1, 8), mode == 2);
      end
      run_stream($sformatf("rnd%0d", it), 1, 0);
    end

    // Exactly NUMWORDS words is accepted
    stim_q.delete();
    build_frame(NUMWORDS, 0);
    run_stream("max_len", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
